imem_arbiter: RTL and testbench

//  Sole owner of the byte-organised instruction memory port.

---
 rtl/imem_arbiter.sv | 145 ++++++++++++++
 tb/tb_imem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: single owner of the byte-wide instruction memory port.
// It shares the port between 32-bit fetch reads and loader word writes.
// Each loader word is written as four consecutive byte writes.
// Optional feature macro: IMEM_ALIGN_CHK_EN. When it is defined, a misaligned
// fetch is granted but never read, and fetch_err pulses one cycle later.
//
//  state | meaning
//  IDLE  | arbitrate; the grant cycle (a fetch grant also issues mem_re)
//  RD    | read data returning; fetch_rvalid pulses
//  WR    | four byte writes, byte_cnt 0..3; ld_done on the last one
module imem_arbiter #(
    parameter int MEM_BYTES    = 1024,
    parameter int MAW          = 10,
    parameter int LD_BURST_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fetch_req,
    input  logic [31:0]    fetch_addr,
    output logic           fetch_gnt,
    output logic           fetch_rvalid,
    output logic [31:0]    fetch_rdata,
    output logic           fetch_err,
    input  logic           ld_req,
    input  logic [31:0]    ld_addr,
    input  logic [31:0]    ld_wdata,
    output logic           ld_gnt,
    output logic           ld_done,
    output logic [MAW-1:0] mem_addr,
    output logic           mem_re,
    output logic           mem_we,
    output logic [7:0]     mem_wdata,
    input  logic [31:0]    mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;

    localparam int SCW = $clog2(LD_BURST_MAX + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(LD_BURST_MAX);

    logic [1:0]     state;
    logic [1:0]     byte_cnt;
    logic [SCW-1:0] starve_cnt;
    logic [MAW-1:0] ld_addr_q;
    logic [31:0]    ld_wdata_q;
    logic [31:0]    rdata_q;
    logic           ld_win;
    logic           misal;
    logic [MAW-1:0] wr_addr;
    logic           unused_addr_hi;

    // Address bits above MAW alias onto the array.
    assign unused_addr_hi = ^{fetch_addr[31:MAW], ld_addr[31:MAW]};

`ifdef IMEM_ALIGN_CHK_EN
    assign misal = (fetch_addr[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    // Arbitration and the combinational memory strobes.
    // Everything is forced low while rst is high so that all outputs read 0 during reset.
    always_comb begin
        ld_win       = ld_req && (!fetch_req || (starve_cnt < STARVE_MAX));
        fetch_gnt    = !rst && (state == IDLE) && fetch_req && !ld_win;
        ld_gnt       = !rst && (state == IDLE) && ld_win;
        mem_re       = fetch_gnt && !misal;
        mem_we       = !rst && (state == WR);
        fetch_rvalid = !rst && (state == RD);
        ld_done      = mem_we && (byte_cnt == 2'd3);
        wr_addr      = ld_addr_q + {{(MAW-2){1'b0}}, byte_cnt};
        mem_addr     = '0;
        mem_wdata    = 8'h00;
        if (mem_we) begin
            mem_addr  = wr_addr;
            mem_wdata = ld_wdata_q[{byte_cnt, 3'b000} +: 8];
        end else if (mem_re) begin
            mem_addr = fetch_addr[MAW-1:0];
        end
        // Read data goes straight through in the RD cycle and is held afterwards.
        fetch_rdata  = fetch_rvalid ? mem_rdata : rdata_q;
    end

    // FSM, request sampling and the byte counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            ld_addr_q  <= '0;
            ld_wdata_q <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_re) begin
                        state <= RD;
                    end else if (ld_gnt) begin
                        state      <= WR;
                        byte_cnt   <= 2'd0;
                        ld_addr_q  <= ld_addr[MAW-1:0];
                        ld_wdata_q <= ld_wdata;
                    end
                end
                RD: begin
                    rdata_q <= mem_rdata;
                    state   <= IDLE;
                end
                WR: begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Count loader grants that overtook a waiting fetch; any fetch grant clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (fetch_gnt) begin
            starve_cnt <= '0;
        end else if (ld_gnt && fetch_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef IMEM_ALIGN_CHK_EN
    // Report a misaligned fetch one cycle after its grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= fetch_gnt && misal;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter. It provides a byte-array memory and a transaction-level reference model.
// A negedge compare process checks every DUT output on every cycle.
module tb_imem_arbiter;

    localparam int LDMAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        fetch_gnt, fetch_rvalid, fetch_err;
    logic [31:0] fetch_rdata;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic [31:0] ld_wdata = 32'h0;
    logic        ld_gnt, ld_done;
    logic [9:0]  mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    imem_arbiter #(.MEM_BYTES(1024), .MAW(10), .LD_BURST_MAX(LDMAX)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_done(ld_done),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory array on the far side of the port
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        logic [9:0] a1, a2, a3;
        a1 = mem_addr + 10'd1;
        a2 = mem_addr + 10'd2;
        a3 = mem_addr + 10'd3;
        if (mem_we) mem[mem_addr] = mem_wdata;
        if (mem_re) mem_rdata <= {mem[a3], mem[a2], mem[a1], mem[mem_addr]};
    end

    // Reference model: queue of planned per-cycle port actions plus a shadow memory
    typedef struct {
        bit         rd;
        logic [9:0] addr;
        logic [7:0] b;
        bit         last;
        logic [31:0] word;
    } op_t;

    op_t         plan[$];
    logic [7:0]  ref_mem [1024];
    int          starve = 0;
    logic [31:0] last_rdata = 32'h0;
    bit          err_pend = 0;

    always @(negedge clk) begin : model_cmp
        logic e_fg, e_lg, e_re, e_we, e_rv, e_done, e_err, lw, mis;
        logic [9:0] e_addr, a;
        logic [7:0] e_wd;
        logic [31:0] w;
        op_t op;
        e_fg = 0; e_lg = 0; e_re = 0; e_we = 0; e_rv = 0; e_done = 0; e_err = 0;
        e_addr = 10'd0; e_wd = 8'h00;
        if (rst) begin
            plan.delete();
            starve = 0;
            last_rdata = 32'h0;
            err_pend = 0;
        end else begin
            e_err = err_pend;
            err_pend = 0;
            if (plan.size() != 0) begin
                op = plan.pop_front();
                if (op.rd) begin
                    e_rv = 1;
                    last_rdata = op.word;
                end else begin
                    e_we = 1; e_addr = op.addr; e_wd = op.b; e_done = op.last;
                    ref_mem[op.addr] = op.b;
                end
            end else begin
                lw = ld_req && (!fetch_req || starve < LDMAX);
                if (lw) begin
                    e_lg = 1;
                    for (int k = 0; k < 4; k++) begin
                        op.rd = 0;
                        op.addr = ld_addr[9:0] + 10'(k);
                        op.b = ld_wdata[8*k +: 8];
                        op.last = (k == 3);
                        op.word = 32'h0;
                        plan.push_back(op);
                    end
                    if (fetch_req && starve < LDMAX) starve++;
                end else if (fetch_req) begin
                    e_fg = 1;
                    starve = 0;
`ifdef IMEM_ALIGN_CHK_EN
                    mis = (fetch_addr[1:0] != 2'b00);
`else
                    mis = 0;
`endif
                    if (mis) begin
                        err_pend = 1;
                    end else begin
                        e_re = 1;
                        e_addr = fetch_addr[9:0];
                        for (int k = 0; k < 4; k++) begin
                            a = fetch_addr[9:0] + 10'(k);
                            w[8*k +: 8] = ref_mem[a];
                        end
                        op.rd = 1; op.addr = e_addr; op.b = 8'h00; op.last = 0; op.word = w;
                        plan.push_back(op);
                    end
                end
            end
        end
        chk("fetch_gnt", {31'd0, fetch_gnt}, {31'd0, e_fg});
        chk("ld_gnt", {31'd0, ld_gnt}, {31'd0, e_lg});
        chk("mem_re", {31'd0, mem_re}, {31'd0, e_re});
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, e_addr});
        chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e_wd});
        chk("ld_done", {31'd0, ld_done}, {31'd0, e_done});
        chk("fetch_rvalid", {31'd0, fetch_rvalid}, {31'd0, e_rv});
        chk("fetch_rdata", fetch_rdata, last_rdata);
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, e_err});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input bit is_fetch, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_fetch ? fetch_gnt : ld_gnt) begin
                ok = 1;
                break;
            end
        end
        chk(is_fetch ? "fetch_gnt_seen" : "ld_gnt_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
        bit ok;
        tick();
        ld_addr = addr; ld_wdata = data; ld_req = 1;
        wait_gnt(0, ok);
        tick();
        ld_req = 0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ld_done) begin
                ok = 1;
                break;
            end
        end
        chk("ld_done_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] data,
                            output bit rv, output bit er);
        bit ok;
        tick();
        fetch_addr = addr; fetch_req = 1;
        wait_gnt(1, ok);
        tick();
        fetch_req = 0;
        @(negedge clk);
        rv = fetch_rvalid;
        er = fetch_err;
        data = fetch_rdata;
    endtask

    logic [31:0] rd;
    bit          rv, er;
    logic [9:0]  order;
    int          n, dones;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        // Test 1: reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fetch_rdata", fetch_rdata, 32'h0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        tick();
        rst = 0;
        repeat (10) tick();

        // Test 2: load 0x10, then fetch it back
        do_load(32'h10, 32'hDEADBEEF);
        do_fetch(32'h10, rd, rv, er);
        chk("t2_byte10", {24'd0, mem[10'h10]}, 32'hEF);
        chk("t2_byte11", {24'd0, mem[10'h11]}, 32'hBE);
        chk("t2_byte12", {24'd0, mem[10'h12]}, 32'hAD);
        chk("t2_byte13", {24'd0, mem[10'h13]}, 32'hDE);
        chk("t2_rvalid", {31'd0, rv}, 32'd1);
        chk("t2_rdata", rd, 32'hDEADBEEF);

        // Test 3: both requests held; loader bursts capped at LD_BURST_MAX
        tick();
        ld_addr = 32'h100; ld_wdata = 32'h04030201; fetch_addr = 32'h100;
        ld_req = 1; fetch_req = 1;
        order = 10'd0; n = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            @(negedge clk);
            if (ld_gnt || fetch_gnt) begin
                order = {order[8:0], ld_gnt};
                n++;
            end
        end
        chk("t3_grant_count", n, 32'd10);
        chk("t3_grant_order", {22'd0, order}, {22'd0, 10'b1111011110});
        tick();
        ld_req = 0; fetch_req = 0;
        repeat (3) tick();

        // Test 4: load wraps past the top of memory
        do_load(32'h3FE, 32'h44332211);
        tick();
        chk("t4_byte3fe", {24'd0, mem[10'h3FE]}, 32'h11);
        chk("t4_byte3ff", {24'd0, mem[10'h3FF]}, 32'h22);
        chk("t4_byte000", {24'd0, mem[10'h000]}, 32'h33);
        chk("t4_byte001", {24'd0, mem[10'h001]}, 32'h44);

        // Test 5: reset in the middle of a load
        tick();
        ld_addr = 32'h200; ld_wdata = 32'hA5A5A5A5; ld_req = 1;
        wait_gnt(0, rv);
        tick();
        ld_req = 0;
        tick();
        rst = 1;
        @(negedge clk);
        chk("t5_rst_we", {31'd0, mem_we}, 32'd0);
        chk("t5_rst_done", {31'd0, ld_done}, 32'd0);
        tick();
        rst = 0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ld_done) dones++;
        end
        chk("t5_no_done", dones, 32'd0);
        chk("t5_byte200", {24'd0, mem[10'h200]}, 32'hA5);
        chk("t5_byte201", {24'd0, mem[10'h201]}, 32'h00);
        do_fetch(32'h10, rd, rv, er);
        chk("t5_fetch_rvalid", {31'd0, rv}, 32'd1);
        chk("t5_fetch_rdata", rd, 32'hDEADBEEF);

        // Test 6: fetch at a misaligned address
        do_load(32'h20, 32'h44332211);
        do_load(32'h24, 32'h88776655);
        do_fetch(32'h22, rd, rv, er);
`ifdef IMEM_ALIGN_CHK_EN
        chk("t6_err", {31'd0, er}, 32'd1);
        chk("t6_rvalid", {31'd0, rv}, 32'd0);
        chk("t6_rdata_held", rd, 32'hDEADBEEF);
`else
        chk("t6_err", {31'd0, er}, 32'd0);
        chk("t6_rvalid", {31'd0, rv}, 32'd1);
        chk("t6_rdata", rd, 32'h66554433);
`endif
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
